// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_pkg
// Description : Shared framing constants and opcode set for the command decoder.
// Revision    : 1.0
// ============================================================================
package cmd_pkg;

    localparam logic [7:0] c_hdr = 8'hA5;
    localparam logic [7:0] c_ack = 8'h06;
    localparam logic [7:0] c_nak = 8'h15;

    typedef enum logic [3:0] {
        OP_SET    = 4'd0,
        OP_INC    = 4'd1,
        OP_DEC    = 4'd2,
        OP_DEF    = 4'd3,
        OP_ALLDEF = 4'd4,
        OP_QUERY  = 4'd5
    } opcode_e;

endpackage
`default_nettype wire

// File: rtl/pulse_sync.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync
// Description : Three-flop synchroniser with rising-edge detect between stages 2 and 3.
// Revision    : 1.0
// ============================================================================
module pulse_sync (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [2:0] r_sync;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], async_in};
        end
    end

    assign rise = r_sync[1] & ~r_sync[2];

endmodule
`default_nettype wire

// File: rtl/cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cmd_decoder
// Description : UART packet decoder driving clamped actuator channels with ACK/NAK and watchdog.
// Revision    : 1.0
// ============================================================================
module cmd_decoder
    import cmd_pkg::*;
#(
    parameter int                        NUM_CH   = 4,
    parameter int                        VAL_W    = 8,
    parameter logic [NUM_CH*VAL_W-1:0]   CH_MIN   = '0,
    parameter logic [NUM_CH*VAL_W-1:0]   CH_MAX   = '1,
    parameter logic [NUM_CH*VAL_W-1:0]   CH_DEF   = '0,
    parameter int                        GAP_CYC  = 1_000_000,
    parameter int                        WDOG_CYC = 50_000_000
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      rx_finish,
    input  logic [7:0]                rx_data,
    input  logic                      rx_error,
    output logic [NUM_CH*VAL_W-1:0]   ch_value,
    output logic                      cmd_ok,
    output logic                      cmd_err,
    output logic                      wdog_tripped,
    output logic                      ack_valid,
    output logic [7:0]                ack_data,
    input  logic                      ack_ready
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_hdr  = 3'd1;
    localparam logic [2:0] c_st_cmd  = 3'd2;
    localparam logic [2:0] c_st_arg  = 3'd3;
    localparam logic [2:0] c_st_exec = 3'd4;

    localparam int                    c_gap_w   = $clog2(GAP_CYC + 1);
    localparam int                    c_wdog_w  = $clog2(WDOG_CYC + 1);
    localparam logic [c_gap_w-1:0]    c_gap_last  = c_gap_w'(GAP_CYC - 1);
    localparam logic [c_wdog_w-1:0]   c_wdog_last = c_wdog_w'(WDOG_CYC - 1);

    logic                 w_rx_evt, w_err_evt;
    logic [2:0]           r_state, w_state_nx;
    logic                 r_pend_vld;
    logic [7:0]           r_pend_data;
    logic                 w_byte_vld;
    logic [7:0]           w_byte;
    logic [7:0]           r_cmd, r_arg, r_chk;
    logic [c_gap_w-1:0]   r_gap_cnt;
    logic [c_wdog_w-1:0]  r_wdog_cnt;
    logic                 r_wdog_trip, w_wdog_exp;
    logic                 w_in_pkt, w_gap_to, w_abort, w_exec, w_valid;
    logic                 r_ack_valid;
    logic [7:0]           r_ack_data, w_reply, w_cur8;
    opcode_e              w_op;
    logic [3:0]           w_ch;
    logic [VAL_W-1:0]     r_ch [NUM_CH];
    logic [VAL_W-1:0]     w_cur, w_min, w_max, w_def, w_arg, w_new, w_diff;
    logic [VAL_W:0]       w_sum;

    pulse_sync u_sync_finish (.sys_clk(sys_clk), .rst_n(rst_n), .async_in(rx_finish), .rise(w_rx_evt));
    pulse_sync u_sync_error  (.sys_clk(sys_clk), .rst_n(rst_n), .async_in(rx_error),  .rise(w_err_evt));

    // A byte parked during EXEC is replayed as the first byte seen in IDLE.
    assign w_byte_vld = w_rx_evt | ((r_state == c_st_idle) & r_pend_vld);
    assign w_byte     = ((r_state == c_st_idle) && r_pend_vld) ? r_pend_data : rx_data;

    assign w_in_pkt = (r_state == c_st_hdr) || (r_state == c_st_cmd) || (r_state == c_st_arg);
    assign w_gap_to = w_in_pkt && (r_gap_cnt == c_gap_last) && !w_rx_evt;
    assign w_abort  = (w_in_pkt && (w_err_evt || w_gap_to)) || ((r_state == c_st_exec) && w_err_evt);
    assign w_exec   = (r_state == c_st_exec) && !w_err_evt;

    assign w_op    = opcode_e'(r_cmd[7:4]);
    assign w_ch    = r_cmd[3:0];
    assign w_valid = (r_chk == (r_cmd ^ r_arg)) && (r_cmd[7:4] <= 4'd5) &&
                     ((w_op == OP_ALLDEF) || ({1'b0, w_ch} < 5'(NUM_CH)));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_st_idle: if (w_byte_vld && (w_byte == c_hdr)) w_state_nx = c_st_hdr;
            c_st_hdr:  if (w_abort) w_state_nx = c_st_idle; else if (w_rx_evt) w_state_nx = c_st_cmd;
            c_st_cmd:  if (w_abort) w_state_nx = c_st_idle; else if (w_rx_evt) w_state_nx = c_st_arg;
            c_st_arg:  if (w_abort) w_state_nx = c_st_idle; else if (w_rx_evt) w_state_nx = c_st_exec;
            default:   w_state_nx = c_st_idle;
        endcase
    end

    always_comb begin
        cmd_ok  = w_exec && w_valid;
        cmd_err = w_abort || (w_exec && !w_valid);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd       <= 8'h00;
            r_arg       <= 8'h00;
            r_chk       <= 8'h00;
            r_pend_vld  <= 1'b0;
            r_pend_data <= 8'h00;
            r_gap_cnt   <= '0;
        end else begin
            if ((r_state == c_st_hdr) && w_rx_evt) r_cmd <= rx_data;
            if ((r_state == c_st_cmd) && w_rx_evt) r_arg <= rx_data;
            if ((r_state == c_st_arg) && w_rx_evt) r_chk <= rx_data;
            if ((r_state == c_st_exec) && w_rx_evt) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= rx_data;
            end else if (r_state == c_st_idle) begin
                r_pend_vld  <= 1'b0;
            end
            if (!w_in_pkt || w_rx_evt) r_gap_cnt <= '0;
            else if (!w_gap_to)        r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    // Counter freezes once tripped; only a successful command rearms it.
    assign w_wdog_exp = !r_wdog_trip && !cmd_ok && (r_wdog_cnt == c_wdog_last);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b0;
        end else if (cmd_ok) begin
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b0;
        end else if (w_wdog_exp) begin
            r_wdog_trip <= 1'b1;
        end else if (!r_wdog_trip) begin
            r_wdog_cnt  <= r_wdog_cnt + 1'b1;
        end
    end

    always_comb begin
        w_cur = '0;
        w_min = '0;
        w_max = '0;
        w_def = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == 4'(i)) begin
                w_cur = r_ch[i];
                w_min = CH_MIN[i*VAL_W +: VAL_W];
                w_max = CH_MAX[i*VAL_W +: VAL_W];
                w_def = CH_DEF[i*VAL_W +: VAL_W];
            end
        end
    end

    generate
        if (VAL_W >= 8) begin : g_arg_wide
            assign w_arg  = VAL_W'(r_arg);
            assign w_cur8 = w_cur[7:0];
        end else begin : g_arg_narrow
            assign w_arg  = r_arg[VAL_W-1:0];
            assign w_cur8 = 8'(w_cur);
        end
    endgenerate

    always_comb begin
        w_sum = {1'b0, w_cur} + {1'b0, w_arg};
        w_diff = w_cur - w_arg;
        w_new = w_cur;
        case (w_op)
            OP_SET:  w_new = (w_arg < w_min) ? w_min : ((w_arg > w_max) ? w_max : w_arg);
            OP_INC:  w_new = (w_sum > {1'b0, w_max}) ? w_max : w_sum[VAL_W-1:0];
            OP_DEC:  w_new = ((w_arg > w_cur) || (w_diff < w_min)) ? w_min : w_diff;
            OP_DEF:  w_new = w_def;
            default: w_new = w_cur;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_ch[i] <= CH_DEF[i*VAL_W +: VAL_W];
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wdog_exp || (cmd_ok && (w_op == OP_ALLDEF)))
                    r_ch[i] <= CH_DEF[i*VAL_W +: VAL_W];
                else if (cmd_ok && (w_ch == 4'(i)) && (w_op != OP_QUERY))
                    r_ch[i] <= w_new;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_out
            assign ch_value[gi*VAL_W +: VAL_W] = r_ch[gi];
        end
    endgenerate

    assign w_reply = !w_valid ? c_nak : ((w_op == OP_QUERY) ? w_cur8 : c_ack);

    // A fresh reply overwrites a pending one and wins over a same-cycle handshake.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_valid <= 1'b0;
            r_ack_data  <= 8'h00;
        end else if (w_exec) begin
            r_ack_valid <= 1'b1;
            r_ack_data  <= w_reply;
        end else if (r_ack_valid && ack_ready) begin
            r_ack_valid <= 1'b0;
        end
    end

    assign ack_valid    = r_ack_valid;
    assign ack_data     = r_ack_data;
    assign wdog_tripped = r_wdog_trip;

endmodule
`default_nettype wire

// File: tb/tb_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_decoder
// Description : Directed self-checking bench for cmd_decoder (4 x 8-bit channels).
// Revision    : 1.0
// ============================================================================
module tb_cmd_decoder;

    localparam int NUM_CH   = 4;
    localparam int VAL_W    = 8;
    localparam int GAP_CYC  = 200;
    localparam int WDOG_CYC = 3000;
    // Channels 0 and 1 share the 150/250/200 profile; the CMD low nibble selects the channel.
    localparam logic [31:0] CH_MIN = {8'd0,   8'd10,  8'd150, 8'd150};
    localparam logic [31:0] CH_MAX = {8'd255, 8'd100, 8'd250, 8'd250};
    localparam logic [31:0] CH_DEF = {8'd0,   8'd50,  8'd200, 8'd200};

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_finish = 1'b0;
    logic        rx_error = 1'b0;
    logic        ack_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] ch_value;
    logic        cmd_ok, cmd_err, wdog_tripped, ack_valid;
    logic [7:0]  ack_data;

    int vectors = 0;
    int miscompares = 0;
    int n_ok = 0;
    int n_err = 0;

    cmd_decoder #(
        .NUM_CH(NUM_CH), .VAL_W(VAL_W), .CH_MIN(CH_MIN), .CH_MAX(CH_MAX),
        .CH_DEF(CH_DEF), .GAP_CYC(GAP_CYC), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .rx_finish(rx_finish), .rx_data(rx_data),
        .rx_error(rx_error), .ch_value(ch_value), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
        .wdog_tripped(wdog_tripped), .ack_valid(ack_valid), .ack_data(ack_data),
        .ack_ready(ack_ready)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (cmd_ok)  n_ok++;
        if (cmd_err) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_data = b;
        rx_finish = 1'b1;
        repeat (4) @(negedge sys_clk);
        rx_finish = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(k);
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic consume_ack();
        @(negedge sys_clk);
        ack_ready = 1'b1;
        @(negedge sys_clk);
        ack_ready = 1'b0;
    endtask

    task automatic pkt_expect(input string tag, input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] k, input logic ok, input logic [7:0] reply,
                              input logic [31:0] exp_ch);
        int ok0, err0;
        ok0 = n_ok;
        err0 = n_err;
        send_pkt(c, a, k);
        chk({tag, " cmd_ok"}, n_ok - ok0, ok ? 1 : 0);
        chk({tag, " cmd_err"}, n_err - err0, ok ? 0 : 1);
        chk({tag, " ack_valid"}, ack_valid, 1);
        chk({tag, " ack_data"}, ack_data, reply);
        chk({tag, " ch_value"}, ch_value, exp_ch);
        consume_ack();
        chk({tag, " ack_clr"}, ack_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ok0, err0;
        repeat (3) @(negedge sys_clk);
        chk("rst ch_value", ch_value, {8'd0, 8'd50, 8'd200, 8'd200});
        chk("rst cmd_ok", cmd_ok, 0);
        chk("rst cmd_err", cmd_err, 0);
        chk("rst wdog", wdog_tripped, 0);
        chk("rst ack_valid", ack_valid, 0);
        chk("rst ack_data", ack_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        pkt_expect("set200",   8'h01, 8'hC8, 8'hC9, 1, 8'h06, {8'd0, 8'd50, 8'd200, 8'd200});
        pkt_expect("set245",   8'h01, 8'hF5, 8'hF4, 1, 8'h06, {8'd0, 8'd50, 8'd245, 8'd200});
        pkt_expect("inc_sat",  8'h11, 8'h0A, 8'h1B, 1, 8'h06, {8'd0, 8'd50, 8'd250, 8'd200});
        pkt_expect("set155",   8'h01, 8'h9B, 8'h9A, 1, 8'h06, {8'd0, 8'd50, 8'd155, 8'd200});
        pkt_expect("dec_floor",8'h21, 8'h14, 8'h35, 1, 8'h06, {8'd0, 8'd50, 8'd150, 8'd200});
        pkt_expect("dec_undf", 8'h21, 8'hFF, 8'hDE, 1, 8'h06, {8'd0, 8'd50, 8'd150, 8'd200});
        pkt_expect("set_hi",   8'h01, 8'hFF, 8'hFE, 1, 8'h06, {8'd0, 8'd50, 8'd250, 8'd200});
        pkt_expect("set_lo",   8'h01, 8'h05, 8'h04, 1, 8'h06, {8'd0, 8'd50, 8'd150, 8'd200});
        pkt_expect("bad_chk",  8'h01, 8'hC8, 8'h00, 0, 8'h15, {8'd0, 8'd50, 8'd150, 8'd200});
        pkt_expect("bad_ch",   8'h07, 8'h00, 8'h07, 0, 8'h15, {8'd0, 8'd50, 8'd150, 8'd200});
        pkt_expect("bad_op",   8'h61, 8'h00, 8'h61, 0, 8'h15, {8'd0, 8'd50, 8'd150, 8'd200});
        pkt_expect("set_ch2",  8'h02, 8'h3C, 8'h3E, 1, 8'h06, {8'd0, 8'd60, 8'd150, 8'd200});
        pkt_expect("query",    8'h52, 8'h00, 8'h52, 1, 8'h3C, {8'd0, 8'd60, 8'd150, 8'd200});
        pkt_expect("def_ch1",  8'h31, 8'h00, 8'h31, 1, 8'h06, {8'd0, 8'd60, 8'd200, 8'd200});
        pkt_expect("set_ch0",  8'h00, 8'hE6, 8'hE6, 1, 8'h06, {8'd0, 8'd60, 8'd200, 8'd230});
        pkt_expect("inc_ch3",  8'h13, 8'hFF, 8'hEC, 1, 8'h06, {8'd255, 8'd60, 8'd200, 8'd230});
        pkt_expect("inc_9bit", 8'h13, 8'h01, 8'h12, 1, 8'h06, {8'd255, 8'd60, 8'd200, 8'd230});
        pkt_expect("alldef",   8'h4F, 8'h00, 8'h4F, 1, 8'h06, {8'd0, 8'd50, 8'd200, 8'd200});

        // Header followed by a framing error: abort without reply.
        err0 = n_err;
        send_byte(8'hA5);
        @(negedge sys_clk);
        rx_error = 1'b1;
        repeat (4) @(negedge sys_clk);
        rx_error = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("rxerr cmd_err", n_err - err0, 1);
        chk("rxerr ack_valid", ack_valid, 0);

        // Header followed by silence: inter-byte timeout.
        err0 = n_err;
        send_byte(8'hA5);
        for (int i = 0; i < 400 && n_err == err0; i++) @(negedge sys_clk);
        chk("gap cmd_err", n_err - err0, 1);
        chk("gap ack_valid", ack_valid, 0);

        // Body bytes without a header are ignored.
        ok0 = n_ok;
        err0 = n_err;
        send_byte(8'h01);
        send_byte(8'hF5);
        send_byte(8'hF4);
        repeat (4) @(negedge sys_clk);
        chk("nohdr cmd_ok", n_ok - ok0, 0);
        chk("nohdr cmd_err", n_err - err0, 0);
        chk("nohdr ch_value", ch_value, {8'd0, 8'd50, 8'd200, 8'd200});

        // Two replies with no TX acceptance: the second overwrites the first.
        send_pkt(8'h01, 8'hAA, 8'hAB);
        chk("ovw first valid", ack_valid, 1);
        chk("ovw first data", ack_data, 8'h06);
        send_pkt(8'h51, 8'h00, 8'h51);
        chk("ovw second valid", ack_valid, 1);
        chk("ovw second data", ack_data, 8'hAA);
        chk("ovw ch_value", ch_value, {8'd0, 8'd50, 8'd170, 8'd200});
        consume_ack();
        chk("ovw ack_clr", ack_valid, 0);

        // Watchdog expiry restores defaults, next good packet clears the flag.
        pkt_expect("wd_set", 8'h00, 8'hE6, 8'hE6, 1, 8'h06, {8'd0, 8'd50, 8'd170, 8'd230});
        repeat (2700) @(negedge sys_clk);
        chk("wd early trip", wdog_tripped, 0);
        chk("wd early ch", ch_value, {8'd0, 8'd50, 8'd170, 8'd230});
        for (int i = 0; i < 600 && !wdog_tripped; i++) @(negedge sys_clk);
        chk("wd tripped", wdog_tripped, 1);
        chk("wd ch_value", ch_value, {8'd0, 8'd50, 8'd200, 8'd200});
        pkt_expect("wd_clear", 8'h31, 8'h00, 8'h31, 1, 8'h06, {8'd0, 8'd50, 8'd200, 8'd200});
        chk("wd cleared", wdog_tripped, 0);

        // Reset mid-packet discards the partial packet.
        pkt_expect("pre_rst", 8'h01, 8'hAA, 8'hAB, 1, 8'h06, {8'd0, 8'd50, 8'd170, 8'd200});
        send_byte(8'hA5);
        send_byte(8'h01);
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("midrst ch_value", ch_value, {8'd0, 8'd50, 8'd200, 8'd200});
        chk("midrst ack_valid", ack_valid, 0);
        rst_n = 1'b1;
        ok0 = n_ok;
        send_byte(8'h01);
        send_byte(8'hF5);
        send_byte(8'hF4);
        repeat (4) @(negedge sys_clk);
        chk("postrst cmd_ok", n_ok - ok0, 0);
        chk("postrst ch_value", ch_value, {8'd0, 8'd50, 8'd200, 8'd200});
        pkt_expect("postrst_pkt", 8'h01, 8'hF5, 8'hF4, 1, 8'h06, {8'd0, 8'd50, 8'd245, 8'd200});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_decoder.md
CMD_DECODER -- requirements
Module: cmd_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of actuator channels, 1..16.
REQ-002 SHALL have parameter VAL_W, default 8: width of each channel value.
REQ-003 SHALL have parameters CH_MIN, CH_MAX and CH_DEF, each NUM_CH*VAL_W bits: per-channel minimum, maximum and default, with channel 0 in the LSBs.
REQ-004 SHALL have parameter GAP_CYC, default 1_000_000: maximum sys_clk cycles allowed between bytes inside one packet.
REQ-005 SHALL have parameter WDOG_CYC, default 50_000_000: maximum sys_clk cycles allowed without a valid packet.
REQ-006 SHALL have ports as follows; reset rst_n is asynchronous, active-low; clock is sys_clk.
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_finish  in  1  byte-done level from the UART receiver; asynchronous to sys_clk.
- rx_data  in  8  received byte; stable while rx_finish is high.
- rx_error  in  1  framing-error level from the UART receiver; asynchronous to sys_clk.
- ch_value  out  NUM_CH*VAL_W  current value of every channel.
- cmd_ok  out  1  one-cycle pulse for each executed packet.
- cmd_err  out  1  one-cycle pulse for each rejected or aborted packet.
- wdog_tripped  out  1  high while the watchdog has expired.
- ack_valid  out  1  reply byte is pending.
- ack_data  out  8  reply byte.
- ack_ready  in  1  the TX path accepts the reply byte.

Function
REQ-007 SHALL pass rx_finish and rx_error through 3-flop synchronisers and act on the rising edge of stage 2 versus stage 3, sampling rx_data in that same cycle.
REQ-008 SHALL accept a 4-byte packet: 0xA5, then CMD = {op[7:4], ch[3:0]}, then ARG, then CHK = CMD ^ ARG.
REQ-009 SHALL implement the FSM states IDLE, HDR, CMD, ARG and EXEC.
- IDLE goes to HDR on byte 0xA5; any other byte is discarded silently.
- HDR goes to CMD on the next byte; CMD goes to ARG on the next byte.
- ARG goes to EXEC on the CHK byte.
- EXEC lasts 1 cycle and then returns to IDLE.
REQ-010 SHALL execute these opcodes in EXEC:
- 0 SET: value = clamp(ARG).
- 1 INC: value = min(value+ARG, max), computed in VAL_W+1 bits.
- 2 DEC: value = max(value-ARG, min), with no underflow.
- 3 DEF: value = default.
- 4 ALLDEF: all channels = default; ch is ignored.
- 5 QUERY: no change.
REQ-011 SHALL reject a packet with a bad CHK, an opcode above 5, or ch >= NUM_CH (except ALLDEF); a rejected packet changes no channel.
REQ-012 SHALL reduce ARG to its low VAL_W bits when VAL_W < 8 and zero-extend it when VAL_W > 8; clamp SHALL bound the result to [CH_MIN, CH_MAX] of the addressed channel.
REQ-013 SHALL reply once per packet that reaches EXEC:
- QUERY -> the channel value, low 8 bits.
- any other valid opcode -> 0x06.
- rejected packet -> 0x15.
REQ-014 SHALL hold ack_valid until a cycle with ack_valid & ack_ready; a new reply while one is pending SHALL overwrite ack_data and keep ack_valid high.
REQ-015 SHALL pulse cmd_ok or cmd_err in the EXEC cycle, and the new channel value SHALL appear on ch_value 1 cycle after EXEC.
REQ-016 SHALL abort to IDLE and pulse cmd_err, with no reply, on an rx_error edge in any state other than IDLE, or after GAP_CYC cycles without a byte in HDR, CMD or ARG.
REQ-017 SHALL reload the watchdog counter on every cmd_ok; on expiry it SHALL set all channels to default and set wdog_tripped, and the next cmd_ok SHALL clear wdog_tripped.
REQ-018 SHALL give a cmd_ok priority over a watchdog expiry in the same cycle: execute the command, reload the counter, and do not trip.
REQ-019 SHALL, on an rx_finish edge during EXEC, register that byte and process it in IDLE on the next cycle without losing it.

Reset
REQ-020 SHALL, while rst_n is low:
- set FSM = IDLE, ch_value = CH_DEF, and cmd_ok = cmd_err = wdog_tripped = ack_valid = 0;
- set ack_data = 0x00 and clear all synchronisers and counters.
REQ-021 SHALL discard a partial packet when reset is asserted mid-packet; after release, a complete new header is required.

Structure
REQ-022 SHALL define the header 0xA5, the ACK/NAK codes 0x06/0x15 and the opcode enum in the shared package cmd_pkg.
REQ-023 SHALL implement the synchroniser-plus-edge-detector as sub-module pulse_sync, instantiated twice.

Verification
REQ-024 SHALL cover these directed scenarios with NUM_CH=4, VAL_W=8, CH0 min/max/def = 150/250/200:
- A5 01 C8 C9 -> ch0=200, cmd_ok, ack 0x06.
- ch0=245, then A5 11 0A 1B -> ch0=250 (saturated), ack 0x06.
- ch0=155, then A5 21 14 35 -> ch0=150 (floored).
- A5 01 C8 00 (bad CHK) -> ch0 unchanged, cmd_err, ack 0x15.
- A5 07 ... (ch=7) -> ack 0x15.
- A5 then rx_error -> IDLE, cmd_err, no reply.
- ch0=230, no packets for WDOG_CYC -> ch0=200 and wdog_tripped=1; the next valid packet clears wdog_tripped.
- ack_ready held low across two packets -> ack_valid stays 1 and ack_data = the second reply.
